// File: rtl/affine_rf_q_pkg.sv
// affine package: default datapath width and the signed word type shared by
// the affine register file, its operand queue and their users.
package affine;

    localparam int N = 16;

    typedef logic signed [N-1:0] word_t;

endpackage

// File: rtl/affine_rf_q_if.sv
// affine_rf_q_if: external operand queue handshake. The operand source is the
// master. The register file (queue owner) is the slave.
interface affine_rf_q_if #(
    parameter int N = affine::N
) ();

    logic signed [N-1:0] ext_data_i;
    logic                ext_valid_i;
    logic                ext_ready_o;
    logic                ext_pop_i;
    logic                ext_avail_o;

    modport master (
        output ext_data_i,
        output ext_valid_i,
        output ext_pop_i,
        input  ext_ready_o,
        input  ext_avail_o
    );

    modport slave (
        input  ext_data_i,
        input  ext_valid_i,
        input  ext_pop_i,
        output ext_ready_o,
        output ext_avail_o
    );

endinterface

// File: rtl/affine_rf_q_fifo.sv
// affine_rf_fifo: QDEPTH-entry operand queue. The head word is presented as 0
// whenever the queue is empty. A count one bit wider than the pointers
// separates full from empty. Ready depends on stored count only, never on pop.
module affine_rf_fifo #(
    parameter int N      = affine::N,
    parameter int QDEPTH = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic signed [N-1:0] i_data,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic                i_pop,
    output logic                o_avail,
    output logic signed [N-1:0] o_head
);

    import affine::*;

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    logic signed [N-1:0] r_mem [QDEPTH];
    logic [PW-1:0]       r_head;
    logic [PW-1:0]       r_tail;
    logic [CW-1:0]       r_count;
    logic                w_push;
    logic                w_pop;

    assign o_ready = (r_count != CW'(QDEPTH));
    assign o_avail = (r_count != '0);
    assign w_push  = i_valid && o_ready;
    assign w_pop   = i_pop && o_avail;
    assign o_head  = o_avail ? r_mem[r_head] : '0;

    // Payload storage: written at the tail on an accepted push.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_tail] <= i_data;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally at QDEPTH.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/affine_rf_q.sv
// affine_rf_q: affine datapath register file. Register 0 maps onto the head of
// the external operand queue. Registers 1..NREG-1 are storage. The accumulator
// pair sits at ACC_BASE/ACC_BASE+1.
// Optional feature macro AFFINE_RF_BYPASS_EN: when defined, read ports and the
// accumulator outputs forward the write committing at the current edge.
module affine_rf_q #(
    parameter  int N        = affine::N,
    parameter  int NREG     = 8,
    localparam int AW       = $clog2(NREG),
    parameter  int ACC_BASE = 2,
    parameter  int QDEPTH   = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    affine_rf_q_if.slave        ext,
    input  logic                we_i,
    input  logic                wdual_i,
    input  logic [AW-1:0]       wd_addr_i,
    input  logic signed [N-1:0] wd_data_i,
    input  logic signed [N-1:0] acc2_i,
    input  logic [AW-1:0]       rs_addr_i,
    input  logic [AW-1:0]       rd_addr_i,
    output logic signed [N-1:0] rs_data_o,
    output logic signed [N-1:0] rd_data_o,
    output logic signed [N-1:0] acc1_o,
    output logic signed [N-1:0] acc2_o
);

    import affine::*;

    logic signed [N-1:0] r_regs [NREG];
    logic signed [N-1:0] w_next [NREG];
    logic signed [N-1:0] w_view [NREG];
    logic signed [N-1:0] w_head;

    affine_rf_fifo #(
        .N      (N),
        .QDEPTH (QDEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_data  (ext.ext_data_i),
        .i_valid (ext.ext_valid_i),
        .o_ready (ext.ext_ready_o),
        .i_pop   (ext.ext_pop_i),
        .o_avail (ext.ext_avail_o),
        .o_head  (w_head)
    );

    // Next register image: dual accumulator write wins; single writes to
    // address 0 are dropped so slot 0 never holds data.
    always_comb begin
        w_next = r_regs;
        if (wdual_i) begin
            w_next[ACC_BASE]     = wd_data_i;
            w_next[ACC_BASE + 1] = acc2_i;
        end else if (we_i && (wd_addr_i != '0)) begin
            w_next[wd_addr_i] = wd_data_i;
        end
    end

    // Storage update; reset clears every register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_regs <= w_next;
        end
    end

    // Read view: the pending image when bypassing, else committed state.
    generate
`ifdef AFFINE_RF_BYPASS_EN
        if (1) begin : g_bypass
            assign w_view = w_next;
        end
`else
        if (1) begin : g_no_bypass
            assign w_view = r_regs;
        end
`endif
    endgenerate

    // Address 0 always comes from the queue head and is never bypassed.
    assign rs_data_o = (rs_addr_i == '0) ? w_head : w_view[rs_addr_i];
    assign rd_data_o = (rd_addr_i == '0) ? w_head : w_view[rd_addr_i];
    assign acc1_o    = w_view[ACC_BASE];
    assign acc2_o    = w_view[ACC_BASE + 1];

endmodule

// File: doc/affine_rf_q.md
# affine_rf_q

Parametrised successor to the affine datapath register file. Adds a configurable register count, a flow-controlled external input queue mapped onto register 0, and optional same-cycle write-to-read bypass. Sits between the affine decode/execute stage and the external operand source. Supplies two combinational read ports plus the fixed accumulator pair outputs.

## Interface
- N, 16: data width in bits (signed datapath)
- NREG, 8: register count; power of two, ≥ 4
- AW, $clog2(NREG): address width (derived, not overridden)
- ACC_BASE, 2: index of accumulator 1; accumulator 2 is ACC_BASE+1; must satisfy 1 ≤ ACC_BASE ≤ NREG-2
- QDEPTH, 2: external queue depth; power of two, ≥ 2

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  asynchronous active-low reset
- ext_data_i  in  N  external operand
- ext_valid_i  in  1  ext_data_i valid
- ext_ready_o  out  1  queue not full
- ext_pop_i  in  1  consume queue head (register 0)
- ext_avail_o  out  1  queue not empty
- we_i  in  1  single write enable
- wdual_i  in  1  dual accumulator write
- wd_addr_i  in  AW  single write address
- wd_data_i  in  N (signed)  write data; accumulator 1 data when wdual_i
- acc2_i  in  N (signed)  accumulator 2 data when wdual_i
- rs_addr_i, rd_addr_i  in  AW  read addresses
- rs_data_o, rd_data_o  out  N (signed)  read data
- acc1_o, acc2_o  out  N (signed)  regs[ACC_BASE], regs[ACC_BASE+1]

## Operation
- Register 0 is not storage. Reads of address 0 return the queue head when ext_avail_o=1 and 0 when the queue is empty.
- Registers 1..NREG-1 are storage.
- Push: ext_valid_i && ext_ready_o writes ext_data_i at the tail.
- Pop: ext_pop_i && ext_avail_o advances the head. A pop on an empty queue is ignored; no state change.
- Push and pop in the same cycle:
  - Non-empty, not full: both occur; count unchanged.
  - Full: ext_ready_o=0, so only the pop occurs.
  - Empty: only the push occurs.
- ext_ready_o = (count != QDEPTH). It is registered-state derived and never depends combinationally on ext_pop_i.
- Write priority:
  - wdual_i=1 writes regs[ACC_BASE] <= wd_data_i and regs[ACC_BASE+1] <= acc2_i. we_i and wd_addr_i are ignored.
  - Otherwise we_i=1 with wd_addr_i != 0 writes regs[wd_addr_i] <= wd_data_i.
  - we_i with wd_addr_i=0 is silently dropped. It never pushes into the queue.
- Read ports are combinational from the current state. rs and rd may address the same register.
- Arithmetic: none; data passes through bit-exact, no extension or saturation.

## Timing
- Reset: all storage registers 0, queue count 0, head/tail pointers 0. Resulting outputs: ext_ready_o=1, ext_avail_o=0, all read outputs 0.
- Reset asserted mid-transfer discards queue contents and any in-flight write.
- Push to ext_avail_o rising: 1 cycle. Data pushed at edge k is readable at address 0 after edge k.
- Register write to read visibility: 1 cycle without bypass; same cycle with bypass (see Configuration).
- Queue pointers wrap modulo QDEPTH. Full and empty are distinguished by a count of width $clog2(QDEPTH)+1.

## Configuration
- AFFINE_RF_BYPASS_EN defined:
  - rs_data_o, rd_data_o, acc1_o and acc2_o forward any write committing at the current edge, covering both single and dual writes.
  - Dual write has priority, consistent with write priority.
  - Address 0 is never bypassed.
- Undefined: all outputs reflect register state only; writes are visible the cycle after commit.

## Structure
- Package affine: N default, and a typedef for signed N-bit words (word_t). Reuse existing N.
- Sub-module affine_rf_fifo: parametrised on N and QDEPTH. Provides push/pop, ready/avail and head-data outputs. The top instantiates one.
- Top holds the storage array, write-priority logic, read muxes and the bypass generate block.

## Test plan
- Reset then idle: read addr 0, 1 and 3 -> all 0; ext_ready_o=1; ext_avail_o=0.
- Push 0x0011, 0x0022 with QDEPTH=2 -> ext_ready_o=0 after second edge. A third valid word 0x0033 is not accepted. Pop -> address 0 reads 0x0022, and ext_ready_o returns to 1 the cycle after the pop.
- Full queue, push 0x0033 and pop together -> only pop occurs. Empty queue, push 0x0044 and pop together -> count 1, head 0x0044.
- we_i=1, wdual_i=1, wd_addr_i=5, wd_data_i=0x1234, acc2_i=0xFEDC -> acc1_o=0x1234, acc2_o=0xFEDC, reg5 unchanged. Also write to addr 0 -> queue unaffected.
- Bypass build: write 0x7FFF to reg 4 while rs_addr_i=4 -> rs_data_o=0x7FFF in the same cycle. Non-bypass build -> old value that cycle, 0x7FFF the next cycle.
- Assert rst_ni low mid-stream with 1 queued word and a pending write -> all outputs 0 immediately, without waiting for a clock edge; ext_avail_o=0.
